// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MADD  = 4'd4,
        MD_MADDU = 4'd5,
        MD_MSUB  = 4'd6,
        MD_MSUBU = 4'd7,
        MD_MTHI  = 4'd8,
        MD_MTLO  = 4'd9
    } mdfunc_t;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic logic is_iter(input logic [3:0] f);
        return f <= 4'd7;
    endfunction

    function automatic logic is_signed(input logic [3:0] f);
        return (f == MD_MULT) || (f == MD_DIV) || (f == MD_MADD) || (f == MD_MSUB);
    endfunction

    function automatic logic is_div(input logic [3:0] f);
        return (f == MD_DIV) || (f == MD_DIVU);
    endfunction

    function automatic logic is_accum(input logic [3:0] f);
        return (f == MD_MADD) || (f == MD_MADDU) || (f == MD_MSUB) || (f == MD_MSUBU);
    endfunction

    function automatic logic is_msub(input logic [3:0] f);
        return (f == MD_MSUB) || (f == MD_MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide on magnitudes.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    input  logic [WIDTH-1:0]     quo,
    output logic [2*WIDTH-1:0]   acc_nxt,
    output logic [WIDTH-1:0]     quo_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: acc = {partial upper, remaining multiplier bits}, shifted right each step.
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: acc low half is the partial remainder, quo shifts dividend bits in from the top.
        trial = {acc[WIDTH-1:0], quo[WIDTH-1]};
        ge    = (trial >= {1'b0, opnd});
        diff  = trial[WIDTH-1:0] - opnd;
        if (div) begin
            acc_nxt = {{WIDTH{1'b0}}, (ge ? diff : trial[WIDTH-1:0])};
            quo_nxt = {quo[WIDTH-2:0], ge};
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
            quo_nxt = quo;
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO; one op at a time via Start/Busy/Done.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [3:0]       MDfunc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [3:0]         func;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   quo, quo_nxt, opnd, a_raw;
    logic               sgn_q, sgn_r, bzero;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_s, hilo_new;
    logic [WIDTH-1:0]   q_s, r_s;

    assign Busy = (state != IDLE);

    always_comb begin
        sa    = is_signed(MDfunc) & A[WIDTH-1];
        sb    = is_signed(MDfunc) & B[WIDTH-1];
        mag_a = sa ? -A : A;
        mag_b = sb ? -B : B;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Start && !Abort && is_iter(MDfunc)) state_nxt = CALC;
            CALC: begin
                if (Abort)          state_nxt = IDLE;
                else if (cnt == '0) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div     (is_div(func)),
        .acc     (acc),
        .opnd    (opnd),
        .quo     (quo),
        .acc_nxt (acc_nxt),
        .quo_nxt (quo_nxt)
    );

    // Sign correction and accumulate, consumed only on the FIX -> IDLE edge.
    always_comb begin
        prod_s   = sgn_q ? -acc : acc;
        q_s      = sgn_q ? -quo : quo;
        r_s      = sgn_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        hilo_new = prod_s;
        if (is_div(func))
            hilo_new = bzero ? {a_raw, {WIDTH{1'b1}}} : {r_s, q_s};
        else if (is_msub(func))
            hilo_new = {HI, LO} - prod_s;
        else if (is_accum(func))
            hilo_new = {HI, LO} + prod_s;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            Done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_nxt;
            Done  <= 1'b0;
            if (state == FIX && !Abort) begin
                {HI, LO} <= hilo_new;
                Done     <= 1'b1;
            end else if (state == IDLE && Start && !Abort) begin
                if (MDfunc == MD_MTHI) begin
                    HI   <= A;
                    Done <= 1'b1;
                end else if (MDfunc == MD_MTLO) begin
                    LO   <= A;
                    Done <= 1'b1;
                end
            end
        end
    end

    // Operand registers reload every idle cycle; only the Start cycle's values matter.
    always_ff @(posedge Clk) begin
        if (state == IDLE) begin
            cnt   <= CW'(WIDTH - 1);
            func  <= MDfunc;
            a_raw <= A;
            bzero <= (B == '0);
            sgn_q <= sa ^ sb;
            sgn_r <= sa;
            if (is_div(MDfunc)) begin
                acc  <= '0;
                quo  <= mag_a;
                opnd <= mag_b;
            end else begin
                acc  <= {{WIDTH{1'b0}}, mag_b};
                quo  <= '0;
                opnd <= mag_a;
            end
        end else if (state == CALC) begin
            acc <= acc_nxt;
            quo <= quo_nxt;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: reference results from native 64-bit arithmetic, checked via a scoreboard queue.
module tb_muldiv;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst, Start, Abort;
    logic [3:0]   MDfunc;
    logic [W-1:0] A, B;
    logic         Busy, Done;
    logic [W-1:0] HI, LO;

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_hl;
    logic [63:0] sb_q[$];

    muldiv #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .MDfunc (MDfunc),
        .A      (A),
        .B      (B),
        .Abort  (Abort),
        .Busy   (Busy),
        .Done   (Done),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sp, sq, sr;
        logic [63:0] up, q64, r64;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (f)
            4'd0: return sp;
            4'd1: return up;
            4'd4: return hl + sp;
            4'd5: return hl + up;
            4'd6: return hl - sp;
            4'd7: return hl - up;
            4'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                q64 = sq;
                r64 = sr;
                return {r64[31:0], q64[31:0]};
            end
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4'd8: return {a, hl[31:0]};
            4'd9: return {hl[63:32], a};
            default: return hl;
        endcase
    endfunction

    // Drives Start for one cycle (cycle N); returns at the negedge inside cycle N+1.
    task automatic start_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        Start  = 1'b1;
        MDfunc = f;
        A      = a;
        B      = b;
        @(negedge Clk);
        Start  = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit abort_at_done);
        int          k, busy_cnt, lat;
        bit          iter;
        logic [63:0] exp;
        iter = (f <= 4'd7);
        lat  = iter ? W + 2 : 1;
        m_hl = model(f, a, b, m_hl);
        sb_q.push_back(m_hl);
        start_op(f, a, b);
        k = 1;
        busy_cnt = 0;
        while (Done !== 1'b1 && k < 100) begin
            if (Busy === 1'b1) busy_cnt++;
            @(negedge Clk);
            k++;
        end
        chk({tag, ":latency"}, 64'(k), 64'(lat));
        chk({tag, ":busy_cycles"}, 64'(busy_cnt), iter ? 64'(W + 1) : 64'd0);
        chk({tag, ":busy_at_done"}, {63'd0, Busy}, 64'd0);
        exp = sb_q.pop_front();
        chk({tag, ":hilo"}, {HI, LO}, exp);
        if (abort_at_done) Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk({tag, ":done_pulse"}, {63'd0, Done}, 64'd0);
        chk({tag, ":hilo_hold"}, {HI, LO}, exp);
    endtask

    task automatic quiet(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
            @(negedge Clk);
        end
        chk({tag, ":no_activity"}, {63'd0, seen}, 64'd0);
        chk({tag, ":hilo_kept"}, {HI, LO}, m_hl);
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; Abort = 1'b0; MDfunc = 4'd0; A = '0; B = '0;
        m_hl = 64'd0;
        repeat (3) @(negedge Clk);
        chk("reset:busy", {63'd0, Busy}, 64'd0);
        chk("reset:done", {63'd0, Done}, 64'd0);
        chk("reset:hi", {32'd0, HI}, 64'd0);
        chk("reset:lo", {32'd0, LO}, 64'd0);
        Rst = 1'b0;
        @(negedge Clk);

        do_op("multu_max", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max:const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        do_op("mult_neg", 4'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult_neg:const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("mthi", 4'd8, 32'd5, 32'd0, 1'b0);
        do_op("mtlo", 4'd9, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op("maddu", 4'd5, 32'd1, 32'd1, 1'b0);
        chk("maddu:const", {HI, LO}, 64'h0000_0006_0000_0000);
        do_op("msub", 4'd6, 32'hFFFF_FFFE, 32'd3, 1'b0);
        do_op("madd_abort_done", 4'd4, 32'h7FFF_FFFF, 32'h8000_0001, 1'b1);
        do_op("msubu", 4'd7, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);

        do_op("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg:const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf:const", {HI, LO}, 64'h0000_0000_8000_0000);
        do_op("divu_zero", 4'd3, 32'h64, 32'd0, 1'b0);
        chk("divu_zero:const", {HI, LO}, 64'h0000_0064_FFFF_FFFF);
        do_op("div_zero", 4'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        do_op("divu", 4'd3, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        do_op("div_negdiv", 4'd2, 32'd100, 32'hFFFF_FFF9, 1'b0);

        // Abort in CALC, with an ignored Start while busy.
        start_op(4'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) @(negedge Clk);
        start_op(4'd3, 32'd50, 32'd5);
        repeat (4) @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort_calc:busy", {63'd0, Busy}, 64'd0);
        quiet("abort_calc", 40);

        start_op(4'd12, 32'h1111_1111, 32'h2222_2222);
        chk("undef:busy", {63'd0, Busy}, 64'd0);
        quiet("undef", 40);

        Abort = 1'b1;
        start_op(4'd8, 32'hAAAA_5555, 32'd0);
        Abort = 1'b0;
        quiet("abort_start_idle", 5);

        // Abort during FIX (cycle N+W+1).
        start_op(4'd1, 32'd1000, 32'd1000);
        repeat (W) @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort_fix:done", {63'd0, Done}, 64'd0);
        quiet("abort_fix", 10);

        do_op("preload_hi", 4'd8, 32'h1234, 32'd0, 1'b0);
        do_op("preload_lo", 4'd9, 32'h1234, 32'd0, 1'b0);
        start_op(4'd2, 32'd1000, 32'd7);
        repeat (19) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        m_hl = 64'd0;
        chk("rst_mid:busy", {63'd0, Busy}, 64'd0);
        chk("rst_mid:hilo", {HI, LO}, 64'd0);
        quiet("rst_mid", 40);
        do_op("after_rst", 4'd0, 32'hFFFF_FF85, 32'h0001_0001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
